// File: rtl/regfile_wb_queue_pkg.sv
// Shared types and constants for the register-file writeback queue.
// Entries pair a destination register index with the value to be written.
package regfile_pkg;

   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DATA_W = 32;

   localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] dest;
      logic [DEF_DATA_W-1:0] data;
   } wbq_entry_t;

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Valid/ready request channel carrying writeback requests into the queue.
// The master is the datapath unit; the slave is the writeback queue.
interface regfile_wb_queue_if
   import regfile_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_reg;
   logic [DATA_W-1:0] in_data;

   modport master (output in_valid, output in_reg, output in_data, input in_ready);
   modport slave  (input in_valid, input in_reg, input in_data, output in_ready);

endinterface

// File: rtl/regfile_wb_queue_bypass.sv
// Youngest-wins match of one lookup index against the occupied queue entries.
// Entries are scanned oldest to youngest, so the last match found is the youngest.
module wbq_bypass_match
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  wbq_entry_t                   entries [DEPTH],
   input  logic [DEPTH-1:0]             occupied,
   input  logic [$clog2(DEPTH)-1:0]     rd_ptr,
   input  logic [DEF_ADDR_W-1:0]        lk_reg,
   output logic                         hit,
   output logic [DEF_DATA_W-1:0]        data
);

   localparam int PW = $clog2(DEPTH);

   always_comb begin
      logic [PW-1:0] idx;
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = rd_ptr + PW'(k);
         if (lk_reg != REG_ZERO && occupied[idx] && entries[idx].dest == lk_reg) begin
            hit  = 1'b1;
            data = entries[idx].data;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback queue: buffers regfile writes, issues one per cycle in FIFO order,
// and exposes youngest-wins bypass of pending values to two lookup ports.
module regfile_wb_queue
   import regfile_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic                       clk,
   input  logic                       rst_n,
   regfile_wb_queue_if.slave          req,
   input  logic                       wb_stall,
   output logic                       RegWrite,
   output logic [ADDR_W-1:0]          writereg,
   output logic [DATA_W-1:0]          writedata,
   input  logic [ADDR_W-1:0]          lk_reg1,
   input  logic [ADDR_W-1:0]          lk_reg2,
   output logic                       lk_hit1,
   output logic                       lk_hit2,
   output logic [DATA_W-1:0]          lk_data1,
   output logic [DATA_W-1:0]          lk_data2,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    occ_cnt;
   wbq_entry_t       mem [DEPTH];
   logic [DEPTH-1:0] occupied;
   logic             push;
   logic             pop;
   logic             has_entry;

   assign has_entry    = (occ_cnt != '0);
   assign pop          = has_entry && !wb_stall;
   assign RegWrite     = pop;
   assign req.in_ready = (occ_cnt < CW'(DEPTH)) || pop;
   // Register-0 requests still handshake but never occupy a slot.
   assign push         = req.in_valid && req.in_ready && (req.in_reg != REG_ZERO);
   assign count        = occ_cnt;
   assign writereg     = has_entry ? mem[rd_ptr].dest : '0;
   assign writedata    = has_entry ? mem[rd_ptr].data : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         occ_cnt <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   occ_cnt <= occ_cnt + 1'b1;
            2'b01:   occ_cnt <= occ_cnt - 1'b1;
            default: occ_cnt <= occ_cnt;
         endcase
      end
   end

   // Storage needs no reset; the occupancy mask hides stale slots.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= '{dest: req.in_reg, data: req.in_data};
   end

   always_comb begin
      logic [PW-1:0] offs;
      occupied = '0;
      offs     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs        = PW'(i) - rd_ptr;
         occupied[i] = ({1'b0, offs} < occ_cnt);
      end
   end

   wbq_bypass_match #(.DEPTH(DEPTH)) u_match1 (
      .entries  (mem),
      .occupied (occupied),
      .rd_ptr   (rd_ptr),
      .lk_reg   (lk_reg1),
      .hit      (lk_hit1),
      .data     (lk_data1)
   );

   wbq_bypass_match #(.DEPTH(DEPTH)) u_match2 (
      .entries  (mem),
      .occupied (occupied),
      .rd_ptr   (rd_ptr),
      .lk_reg   (lk_reg2),
      .hit      (lk_hit2),
      .data     (lk_data2)
   );

endmodule
